// File: rtl/seg_scan_pkg.sv
// Shared types and width helpers for the seven-segment scan controller.
// Contents: width helpers, the BLANK/DRIVE slot state type, ALL_OFF anode constant.
package seg_scan_pkg;

  // Counter width for a modulus of div (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Digit index width for n digits (never below 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Anodes are active-low; sliced to the digit count by the user.
  localparam logic [7:0] ALL_OFF = 8'hFF;

endpackage

// File: rtl/seg_scan_if.sv
// Host write port and display outputs of the scan controller.
// master: host side (drives disp_en, wr_valid, wr_data).
// slave : controller side (drives wr_ready, digit_val, an, digit_idx, frame_done).
interface seg_scan_if
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDX_W  = idx_width(NUM_DIGITS);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  logic              disp_en;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        digit_val;
  logic [NUM_DIGITS-1:0] an;
  logic [IDX_W-1:0]  digit_idx;
  logic              frame_done;

  modport master (
    output disp_en, wr_valid, wr_data,
    input  wr_ready, digit_val, an, digit_idx, frame_done
  );

  modport slave (
    input  disp_en, wr_valid, wr_data,
    output wr_ready, digit_val, an, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot timer: counts 0..REFRESH_DIV-1 and wraps every slot.
// Ports: clk, rst (sync, active-high);
//   slot_blank_done - high on the last BLANK cycle of a slot
//   slot_pre_done   - high on the second-to-last cycle of a slot
//   slot_done       - high on the last cycle of a slot
// All pulses are registered (decoded from the next count value).
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic slot_blank_done,
  output logic slot_pre_done,
  output logic slot_done
);
  localparam int unsigned CNT_W = cnt_width(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count with wrap at the end of the slot.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (cnt == CNT_W'(REFRESH_DIV - 1)) cnt_nxt = '0;
  end

  // Count register and pulses decoded one cycle early so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      slot_blank_done <= (BLANK_CYCLES == 1);
      slot_pre_done   <= (REFRESH_DIV == 2);
      slot_done       <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      slot_blank_done <= (cnt_nxt == CNT_W'(BLANK_CYCLES - 1));
      slot_pre_done   <= (cnt_nxt == CNT_W'(REFRESH_DIV - 2));
      slot_done       <= (cnt_nxt == CNT_W'(REFRESH_DIV - 1));
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered
// display word committed only at frame boundaries.
// Ports: clk, rst (sync, active-high), bus (seg_scan_if.slave):
//   disp_en, wr_valid/wr_ready/wr_data in; digit_val, an (active-low),
//   digit_idx, frame_done out.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to keep leading-zero
// digits dark (digit 0 is always driven).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);
  localparam int unsigned IDX_W  = idx_width(NUM_DIGITS);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ALL_OFF[NUM_DIGITS-1:0];
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [DATA_W-1:0]     shadow;
  logic [DATA_W-1:0]     active;
  logic [DATA_W-1:0]     active_nxt;
  logic                  pending;
  logic                  commit;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] drive_an;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  blank_sel;
  logic [3:0]            digit_val_q;
  logic                  frame_done_q;
  logic                  slot_blank_done;
  logic                  slot_pre_done;
  logic                  slot_done;

  seg_scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .slot_blank_done (slot_blank_done),
    .slot_pre_done   (slot_pre_done),
    .slot_done       (slot_done)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // Bit i set when digit i and every more-significant digit are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] v);
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] m;
    m          = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (v[4*i +: 4] == 4'h0);
      m[i]       = upper_zero;
    end
    return m;
  endfunction

  // Mask tracks active: reset value is the mask of an all-zero word.
  always_ff @(posedge clk) begin
    if (rst)         blank_mask <= AN_OFF & ~NUM_DIGITS'(1);
    else if (commit) blank_mask <= lz_mask(shadow);
  end
`else
  assign blank_mask = '0;
`endif

  // Commit and next-index decode; the anode pattern for the current slot.
  always_comb begin
    commit     = frame_done_q & pending;
    active_nxt = commit ? shadow : active;
    idx_nxt    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    blank_sel  = 1'(blank_mask >> idx);
    drive_an   = blank_sel ? AN_OFF : ~(NUM_DIGITS'(1) << idx);
  end

  // Slot FSM, digit index, double buffer and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BLANK;
      idx          <= '0;
      an_q         <= AN_OFF;
      digit_val_q  <= 4'h0;
      frame_done_q <= 1'b0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
    end else begin
      // Asserted during the final DRIVE cycle of the last digit.
      frame_done_q <= slot_pre_done & (idx == LAST_IDX);

      case (state)
        BLANK: begin
          if (slot_blank_done) begin
            state <= DRIVE;
            an_q  <= drive_an;
          end
        end
        DRIVE: begin
          if (slot_done) begin
            state       <= BLANK;
            an_q        <= AN_OFF;
            idx         <= idx_nxt;
            // Uses the post-commit word so a new frame starts with new data.
            digit_val_q <= 4'(active_nxt >> {idx_nxt, 2'b00});
          end
        end
        default: state <= BLANK;
      endcase

      // Transfer and commit are exclusive: a transfer needs pending=0.
      if (commit) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (bus.wr_valid && !pending) begin
        shadow  <= bus.wr_data;
        pending <= 1'b1;
      end
    end
  end

  assign bus.an         = bus.disp_en ? an_q : AN_OFF;
  assign bus.digit_val  = digit_val_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_q;
  assign bus.wr_ready   = ~pending;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Honours SEG_SCAN_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_ctrl;
  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned BLK = 2;
  localparam int unsigned FRAME = ND * DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycle count since reset plus the committed/pending words.
  int unsigned t = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pending = 1'b0;
  bit          m_live = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit lead_blank(input logic [15:0] v, input int unsigned i);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    return (i != 0) && ((v >> (4 * i)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      if ((t % FRAME) == FRAME - 1 && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end else if (bus.wr_valid && !m_pending) begin
        m_shadow  = bus.wr_data;
        m_pending = 1'b1;
      end
      t++;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      int unsigned pos, di;
      logic [3:0] e_an;
      pos  = t % DIV;
      di   = (t / DIV) % ND;
      e_an = (bus.disp_en && pos >= BLK && !lead_blank(m_active, di))
             ? 4'(~(4'b0001 << di)) : 4'hF;
      chk("model an", 16'(bus.an), 16'(e_an));
      chk("model digit_val", 16'(bus.digit_val), 16'(m_active >> (4 * di)) & 16'hF);
      chk("model digit_idx", 16'(bus.digit_idx), 16'(di));
      chk("model frame_done", 16'(bus.frame_done), 16'((t % FRAME) == FRAME - 1));
      chk("model wr_ready", 16'(bus.wr_ready), 16'(!m_pending));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (bus.frame_done !== 1'b1 && k < 2 * FRAME) begin
      step();
      k++;
    end
    chk("wait_frame", 16'(bus.frame_done), 16'h1);
  endtask

  task automatic write_word(input logic [15:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    step();
    bus.wr_valid = 1'b0;
  endtask

  // From slot-0 start, checks each slot's nibble and DRIVE anodes.
  task automatic walk_frame(input logic [15:0] dvs, input logic [15:0] ans);
    for (int d = 0; d < ND; d++) begin
      repeat (BLK) step();
      chk("pin walk digit_val", 16'(bus.digit_val), (dvs >> (4 * d)) & 16'hF);
      chk("pin walk an", 16'(bus.an), (ans >> (4 * d)) & 16'hF);
      repeat (DIV - BLK) step();
    end
  endtask

  initial begin
    int fdc;
    int k;
    rst = 1'b1;
    bus.disp_en  = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    repeat (2) step();
    rst = 1'b0;

    // Reset then idle (cycle 0).
    chk("pin reset an", 16'(bus.an), 16'hF);
    chk("pin reset wr_ready", 16'(bus.wr_ready), 16'h1);
    chk("pin reset digit_idx", 16'(bus.digit_idx), 16'h0);
    repeat (2) step();
    chk("pin drive0 an", 16'(bus.an), 16'hE);
    chk("pin drive0 digit_val", 16'(bus.digit_val), 16'h0);
    repeat (5) step();
    chk("pin drive0 last an", 16'(bus.an), 16'hE);
    step();
    chk("pin slot1 blank an", 16'(bus.an), 16'hF);
    chk("pin slot1 idx", 16'(bus.digit_idx), 16'h1);
    repeat (23) step();
    chk("pin frame_done 31", 16'(bus.frame_done), 16'h1);
    step();
    chk("pin frame_done 32", 16'(bus.frame_done), 16'h0);

    // Mid-frame write of 1A3F.
    repeat (8) step();
    write_word(16'h1A3F);
    chk("pin wr_ready after capture", 16'(bus.wr_ready), 16'h0);
    chk("pin old value kept", 16'(bus.digit_val), 16'h0);
    wait_frame();
    chk("pin wr_ready at boundary", 16'(bus.wr_ready), 16'h0);
    step();
    chk("pin wr_ready after commit", 16'(bus.wr_ready), 16'h1);
    walk_frame(16'h1A3F, 16'h7BDE);

    // Write on the exact boundary cycle.
    wait_frame();
    write_word(16'h5678);
    chk("pin boundary capture wr_ready", 16'(bus.wr_ready), 16'h0);
    chk("pin boundary not committed", 16'(bus.digit_val), 16'hF);
    wait_frame();
    step();
    chk("pin boundary committed late", 16'(bus.digit_val), 16'h8);

    // Display disabled for a full frame.
    bus.disp_en = 1'b0;
    fdc = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      step();
      chk("pin disabled an", 16'(bus.an), 16'hF);
      if (bus.frame_done === 1'b1) fdc++;
    end
    chk("pin disabled frame_done count", 16'(fdc), 16'h1);
    bus.disp_en = 1'b1;

    // Reset during DRIVE of digit 2 with a word pending.
    write_word(16'h9999);
    k = 0;
    while (bus.digit_idx !== 2'd2 && k < int'(FRAME)) begin
      step();
      k++;
    end
    chk("pin reach digit 2", 16'(bus.digit_idx), 16'h2);
    repeat (BLK + 1) step();
    chk("pin digit 2 drive an", 16'(bus.an), 16'hB);
    rst = 1'b1;
    step();
    chk("pin mid reset an", 16'(bus.an), 16'hF);
    chk("pin mid reset digit_val", 16'(bus.digit_val), 16'h0);
    chk("pin mid reset digit_idx", 16'(bus.digit_idx), 16'h0);
    chk("pin mid reset wr_ready", 16'(bus.wr_ready), 16'h1);
    chk("pin mid reset frame_done", 16'(bus.frame_done), 16'h0);
    rst = 1'b0;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    write_word(16'h0040);
    wait_frame();
    step();
    walk_frame(16'h0040, 16'hFFDE);
    write_word(16'h0000);
    wait_frame();
    step();
    walk_frame(16'h0000, 16'hFFFE);
`endif

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst          = ($urandom_range(0, 599) == 0);
      bus.disp_en  = ($urandom_range(0, 7) != 0);
      bus.wr_valid = ($urandom_range(0, 3) == 0);
      bus.wr_data  = 16'($urandom) >> (4 * $urandom_range(0, 4));
    end
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit seven-segment display.
- Shares one 4-bit hex-to-seven-segment decoder between NUM_DIGITS digits:
  - presents one nibble at a time on the decoder inputs;
  - drives the matching active-low anode enable.
- Host writes a full display word through a valid/ready handshake. The word is double-buffered and committed only at frame boundaries, so the display never shows a partially updated value.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot (BLANK plus DRIVE); must be at least 2.
- BLANK_CYCLES, 2: cycles per slot with all anodes off (ghosting guard); must be at least 1 and less than REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- disp_en  in  1  1 = display enabled; 0 = all anodes off, scanning continues.
- wr_valid  in  1  host presents wr_data.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  4*NUM_DIGITS  packed nibbles; bits [3:0] are digit 0 (rightmost).
- digit_val  out  4  nibble to decoder inputs (w = bit3, x, y, z = bit0).
- an  out  NUM_DIGITS  anode enables, active-low; an[0] is digit 0.
- digit_idx  out  clog2(NUM_DIGITS), minimum 1  current slot index.
- frame_done  out  1  one-cycle pulse at frame boundary.

Behaviour:
- Reset, applied on any clock edge where rst=1, including mid-frame or mid-handshake:
  - an all 1s, digit_val 0, digit_idx 0, frame_done 0, wr_ready 1;
  - shadow and active registers 0, pending 0, slot counter 0, state BLANK.
- State machine, per slot:
  - BLANK: an all 1s for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: an[digit_idx]=0 (only when disp_en=1) for REFRESH_DIV-BLANK_CYCLES cycles, then go to BLANK of the next index.
- Slot counter: width clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1 and wraps to 0 on every slot change.
- digit_val:
  - registered; equals active[4*digit_idx +: 4] and updates on the same edge digit_idx changes;
  - is therefore stable for the whole BLANK and DRIVE of a slot.
- Index wrap: NUM_DIGITS-1 goes to 0. When NUM_DIGITS=1 the index stays 0 and every slot ends a frame.
- Frame boundary:
  - the cycle the last DRIVE cycle of digit NUM_DIGITS-1 completes;
  - frame_done=1 for exactly that cycle;
  - if pending=1, active<=shadow and pending<=0 on that edge.
- Handshake:
  - wr_ready = !pending;
  - transfer when wr_valid & wr_ready: shadow<=wr_data, pending<=1;
  - wr_ready drops the next cycle; wr_valid while wr_ready=0 is ignored (the host must hold it);
  - a transfer on the boundary cycle itself is not committed until the following boundary;
  - wr_ready is 0 from capture until one cycle after the commit edge.
- disp_en=0:
  - an forced all 1s combinationally from registered state;
  - the counter, index, frame_done and commits proceed unchanged.
- an and digit_val are registered outputs (one cycle after the state change). No combinational path exists from wr_* to display outputs.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - a digit whose nibble is 0 and whose more-significant nibbles in active are all 0 keeps its anode high during DRIVE;
  - digit 0 is never blanked, so a value of 0 shows a single "0";
  - the blanking mask is computed from active and registered alongside it.
- Undefined: all digits are driven, including leading zeros.

Decomposition:
- Package seg_scan_pkg:
  - localparam helpers for counter and index widths;
  - a 1-bit state typedef with encodings BLANK=0 and DRIVE=1;
  - constant ALL_OFF for the anode bus.
- Sub-module seg_scan_timer: the slot counter. Emits slot_blank_done and slot_done pulses. Parameters REFRESH_DIV and BLANK_CYCLES.
- Top level holds the FSM, index, double buffer and handshake.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then idle:
  - an=4'b1111, wr_ready=1;
  - slot 0 DRIVE starts at cycle 2; an=4'b1110 for 6 cycles; digit_val=0;
  - frame_done pulses every 32 cycles.
- Write 16'h1A3F mid-frame:
  - wr_ready=0 next cycle; display keeps its old value until the boundary;
  - next frame: digit_val goes F, 3, A, 1 with an = 1110, 1101, 1011, 0111;
  - wr_ready returns 1 one cycle after the boundary.
- Write on the exact boundary cycle while pending=0:
  - captured, not committed that frame;
  - the new value appears one frame later.
- disp_en=0 for one full frame: an stays 4'b1111; frame_done still pulses at 32-cycle spacing.
- Assert rst during DRIVE of digit 2 with pending=1: next cycle all reset values hold; pending is lost; wr_ready=1.
- With SEG_SCAN_LEADING_ZERO_BLANK_EN defined:
  - write 16'h0040: digits 3 and 2 stay dark; digits 1 and 0 drive 4 and 0;
  - write 16'h0000: only digit 0 drives.
